// File: rtl/lockable_reg_bank.sv
// Bank of NREGS lockable registers with sticky per-register lock bits.
// Writes to locked registers are refused unless a key-checked debug unlock
// is open; the unlock window times out, and too many consecutive bad keys
// block debug access until the next reset.
module lockable_reg_bank #(
    parameter int                 WIDTH         = 16,
    parameter int                 NREGS         = 4,
    parameter int                 KEY_W         = 32,
    parameter logic [KEY_W-1:0]   DBG_KEY       = 32'hA5C3_5A3C,
    parameter int                 UNLOCK_CYCLES = 256,
    parameter int                 MAX_FAILS     = 3,
    localparam int                AW            = $clog2(NREGS)
) (
    input  logic               Clk,
    input  logic               resetn,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               lock_req,
    input  logic [AW-1:0]      lock_addr,
    input  logic [AW-1:0]      rd_addr,
    output logic [WIDTH-1:0]   rd_data,
    input  logic               dbg_req,
    input  logic [KEY_W-1:0]   dbg_key,
    output logic               wr_err,
    output logic [NREGS-1:0]   lock_status,
    output logic               dbg_unlocked,
    output logic               dbg_blocked
);

    // Timer holds UNLOCK_CYCLES-1 down to 0; fail counter must reach MAX_FAILS.
    localparam int TW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(UNLOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_OPEN    = 2'd2,
        S_BLOCKED = 2'd3
    } state_t;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_rd_data;
    logic [NREGS-1:0] r_lock;
    logic             r_wr_err;

    state_t           r_state;
    state_t           w_state_next;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] w_key_next;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_next;
    logic [FW-1:0]    r_fail_cnt;
    logic [FW-1:0]    w_fail_next;
    logic [FW-1:0]    w_fail_inc;

    logic             w_open;
    logic [NREGS-1:0] w_wr_sel;
    logic [NREGS-1:0] w_lock_sel;
    logic             w_wr_reject;
    logic [WIDTH-1:0] w_rd_val;

    // The write sees the unlock state of the current cycle, so a write on the
    // last OPEN cycle still lands.
    assign w_open = (r_state == S_OPEN);

    // Per-register decode: an index with no matching register (only possible
    // when NREGS is not a power of two) selects nothing, which is what makes
    // out-of-range writes reject and out-of-range lock requests vanish.
    // The pre-edge lock bit is used, so a same-cycle write+lock still writes.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_sel
            assign w_wr_sel[gi]   = wr_en && (wr_addr == AW'(gi)) &&
                                    (!r_lock[gi] || w_open);
            assign w_lock_sel[gi] = lock_req && (lock_addr == AW'(gi));
        end
    endgenerate

    assign w_wr_reject = wr_en && (w_wr_sel == '0);

    // Read mux; unmatched addresses read as zero.
    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_addr == AW'(i)) begin
                w_rd_val = r_regs[i];
            end
        end
    end

    // Register bank, sticky lock bits, registered read and write-error pulse.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_lock    <= '0;
            r_rd_data <= '0;
            r_wr_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
            r_lock    <= r_lock | w_lock_sel;
            r_rd_data <= w_rd_val;
            r_wr_err  <= w_wr_reject;
        end
    end

    // Debug unlock state register with its key, timer and failure counter.
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_timer    <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_key      <= w_key_next;
            r_timer    <= w_timer_next;
            r_fail_cnt <= w_fail_next;
        end
    end

    assign w_fail_inc = r_fail_cnt + FW'(1);

    // Debug unlock next-state: key check, countdown, escalation to BLOCKED.
    always_comb begin
        w_state_next = r_state;
        w_key_next   = r_key;
        w_timer_next = r_timer;
        w_fail_next  = r_fail_cnt;
        case (r_state)
            S_IDLE: begin
                if (dbg_req) begin
                    w_key_next   = dbg_key;
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_key == DBG_KEY) begin
                    w_state_next = S_OPEN;
                    w_timer_next = TIMER_LOAD;
                    w_fail_next  = '0;
                end else begin
                    w_fail_next  = w_fail_inc;
                    w_state_next = (w_fail_inc == FAIL_LIMIT) ? S_BLOCKED : S_IDLE;
                end
            end
            S_OPEN: begin
                if (dbg_req || (r_timer == '0)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            S_BLOCKED: begin
                w_state_next = S_BLOCKED;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign rd_data      = r_rd_data;
    assign wr_err       = r_wr_err;
    assign lock_status  = r_lock;
    assign dbg_unlocked = (r_state == S_OPEN);
    assign dbg_blocked  = (r_state == S_BLOCKED);

endmodule
